// File: rtl/joy_serial_scanner.sv
// -----------------------------------------------------------------------------
// joy_serial_scanner
//
// Purpose:
//   Scans two joysticks through a daisy-chained 74HC165 parallel-in/serial-out
//   shift-register chain. A free-running divider produces a scan tick. The
//   controller pulses the parallel-load strobe and clocks NBITS bits out of the
//   chain. It then publishes the decoded frame as two active-high button words.
//
// Parameters:
//   CLK_DIV : clk cycles per scan tick (>= 2)
//   NBITS   : total chain bits per frame (even, 2..32)
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   enable       in   allows the next frame to start (never aborts a frame)
//   JOY_DATA     in   serial data from the chain, buttons active-low
//   JOY_CLK      out  shift clock to the chain
//   JOY_LOAD_N   out  parallel-load strobe, active-low
//   joy1         out  NBITS/2 bits, joystick 1, active-high pressed
//   joy2         out  NBITS/2 bits, joystick 2, active-high pressed
//   frame_valid  out  one-cycle pulse when joy1/joy2 update
//
// Every output is a flop. Neither JOY_DATA nor enable has a combinational
// path to any output.
// -----------------------------------------------------------------------------
module joy_serial_scanner #(
  parameter int CLK_DIV = 8,
  parameter int NBITS   = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               JOY_DATA,
  output logic               JOY_CLK,
  output logic               JOY_LOAD_N,
  output logic [NBITS/2-1:0] joy1,
  output logic [NBITS/2-1:0] joy2,
  output logic               frame_valid
);

  localparam int HALF  = NBITS / 2;
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (NBITS > 2) ? $clog2(NBITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

  // FSM encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SHIFT0 = 3'd2;
  localparam logic [2:0] S_SHIFT1 = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [NBITS-1:0] r_sreg;
  logic             w_tick;
  logic             w_last_bit;

  // ---------------------------------------------------------------------------
  // Scan-tick divider. It free-runs and is independent of the FSM, so the tick
  // phase depends only on the time since reset. The tick is high for the whole
  // cycle in which the divider holds its terminal count.
  // ---------------------------------------------------------------------------
  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_last_bit = (r_cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Frame controller.
  //   IDLE   -> LOAD   : tick && enable, strobe JOY_LOAD_N low for one tick
  //   LOAD   -> SHIFT0 : tick, release the strobe, clear the bit counter
  //   SHIFT0 -> SHIFT1 : tick, sample JOY_DATA, raise JOY_CLK
  //   SHIFT1 -> SHIFT0 : tick, lower JOY_CLK, next bit
  //   SHIFT1 -> DONE   : tick on the last bit
  //   DONE   -> IDLE   : unconditional, publish the frame
  //
  // JOY_DATA is sampled on the same edge that raises JOY_CLK. The sample is
  // therefore the bit the chain presented before this shift. The chain's
  // current MSB-side output lands in the sreg LSB, and the register shifts
  // left. After NBITS shifts, the first bit sits in the MSB, which is joy1's
  // MSB.
  //
  // JOY_LOAD_N is only low in LOAD. JOY_CLK is only high in SHIFT1. These are
  // different states, so the two can never be active together.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sreg     <= '0;
      JOY_CLK    <= 1'b0;
      JOY_LOAD_N <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          JOY_CLK <= 1'b0;
          if (w_tick && enable) begin
            r_state    <= S_LOAD;
            JOY_LOAD_N <= 1'b0;
          end
        end

        S_LOAD: begin
          if (w_tick) begin
            r_state    <= S_SHIFT0;
            JOY_LOAD_N <= 1'b1;
            r_cnt      <= '0;
          end
        end

        S_SHIFT0: begin
          if (w_tick) begin
            r_state <= S_SHIFT1;
            r_sreg  <= {r_sreg[NBITS-2:0], JOY_DATA};
            JOY_CLK <= 1'b1;
          end
        end

        S_SHIFT1: begin
          if (w_tick) begin
            JOY_CLK <= 1'b0;
            if (w_last_bit) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_SHIFT0;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state    <= S_IDLE;
          JOY_CLK    <= 1'b0;
          JOY_LOAD_N <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output frame. It is written only from DONE, so a partial frame is never
  // visible. A reset during a frame drops the frame: the FSM goes back to
  // IDLE before it reaches DONE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      joy1        <= '0;
      joy2        <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (r_state == S_DONE) begin
        joy1        <= ~r_sreg[NBITS-1:HALF];
        joy2        <= ~r_sreg[HALF-1:0];
        frame_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_joy_serial_scanner.sv
// -----------------------------------------------------------------------------
// tb_joy_serial_scanner
//
// Purpose:
//   Directed self-checking bench for joy_serial_scanner. It drives a default
//   instance (CLK_DIV=8, NBITS=24) and a small instance (CLK_DIV=2, NBITS=4).
//   Each instance talks to a behavioural '165 chain model: the model loads
//   its pattern while JOY_LOAD_N is low and shifts left after each rising
//   JOY_CLK, and its MSB drives JOY_DATA.
// -----------------------------------------------------------------------------
module tb_joy_serial_scanner;

  logic        clk;
  logic        rst;
  logic        en;
  logic        en2;

  // default instance
  logic        jdata, jclk, jload_n, fv;
  logic [11:0] joy1, joy2;
  logic [23:0] pat, chain;
  logic        jclk_d;

  // small instance
  logic        jdata2, jclk2, jload_n2, fv2;
  logic [1:0]  joy1s, joy2s;
  logic [3:0]  pat2, chain2;
  logic        jclk2_d;

  int n_assert;
  int n_fail;
  int viol;

  joy_serial_scanner u_dut (
    .clk(clk), .reset(rst), .enable(en), .JOY_DATA(jdata),
    .JOY_CLK(jclk), .JOY_LOAD_N(jload_n), .joy1(joy1), .joy2(joy2),
    .frame_valid(fv)
  );

  joy_serial_scanner #(.CLK_DIV(2), .NBITS(4)) u_small (
    .clk(clk), .reset(rst), .enable(en2), .JOY_DATA(jdata2),
    .JOY_CLK(jclk2), .JOY_LOAD_N(jload_n2), .joy1(joy1s), .joy2(joy2s),
    .frame_valid(fv2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain models
  assign jdata  = chain[23];
  assign jdata2 = chain2[3];

  always @(posedge clk) begin
    jclk_d <= jclk;
    if (!jload_n) chain <= pat;
    else if (jclk && !jclk_d) chain <= {chain[22:0], 1'b1};
  end

  always @(posedge clk) begin
    jclk2_d <= jclk2;
    if (!jload_n2) chain2 <= pat2;
    else if (jclk2 && !jclk2_d) chain2 <= {chain2[2:0], 1'b1};
  end

  // Strobe/clock overlap monitor on both instances
  initial viol = 0;
  always @(negedge clk) begin
    if (!jload_n && jclk) viol++;
    if (!jload_n2 && jclk2) viol++;
  end

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    int n;
    rst = 1'b1; en = 1'b1; en2 = 1'b1;
    pat = 24'hFFFFFF; pat2 = 4'b0110;
    repeat (3) @(negedge clk);
    n_assert++; if (jclk !== 1'b0) begin n_fail++; $display("FAIL reset_jclk got %b want 0", jclk); end
    n_assert++; if (jload_n !== 1'b1) begin n_fail++; $display("FAIL reset_load_n got %b want 1", jload_n); end
    n_assert++; if (joy1 !== 12'h000) begin n_fail++; $display("FAIL reset_joy1 got %h want 000", joy1); end
    n_assert++; if (joy2 !== 12'h000) begin n_fail++; $display("FAIL reset_joy2 got %h want 000", joy2); end
    n_assert++; if (fv !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b want 0", fv); end
    rst = 1'b0;
    // Ticks land on edges 8,16,...; 50 ticks, then DONE, so fv is seen after edge 401.
    n = 0;
    while (n < 1000) begin
      @(negedge clk); n++;
      if (fv === 1'b1) break;
    end
    n_assert++; if (n != 401) begin n_fail++; $display("FAIL first_frame_latency got %0d want 401", n); end
  endtask

  task automatic test_no_press;
    int n;
    n_assert++; if (joy1 !== 12'h000) begin n_fail++; $display("FAIL nopress_joy1 got %h want 000", joy1); end
    n_assert++; if (joy2 !== 12'h000) begin n_fail++; $display("FAIL nopress_joy2 got %h want 000", joy2); end
    n = 0;
    while (n < 1000) begin
      @(negedge clk); n++;
      if (fv === 1'b1) break;
    end
    n_assert++; if (n != 400) begin n_fail++; $display("FAIL frame_period got %0d want 400", n); end
  endtask

  task automatic test_edge_bits;
    int n;
    pat = 24'h7FFFFE;
    n = 0;
    while (n < 1000) begin
      @(negedge clk); n++;
      if (fv === 1'b1) break;
    end
    n_assert++; if (joy1 !== 12'h800) begin n_fail++; $display("FAIL edge_joy1 got %h want 800", joy1); end
    n_assert++; if (joy2 !== 12'h001) begin n_fail++; $display("FAIL edge_joy2 got %h want 001", joy2); end
  endtask

  task automatic test_mixed;
    int n, hi, lo, chg;
    logic [11:0] p1, p2;
    pat = 24'h5A3C96;
    p1 = joy1; p2 = joy2;
    n = 0; hi = 0; lo = 0; chg = 0;
    while (n < 1000) begin
      @(negedge clk); n++;
      if (fv === 1'b1) break;
      if (jclk === 1'b1) hi++;
      if (jload_n === 1'b0) lo++;
      if (joy1 !== p1 || joy2 !== p2) chg++;
    end
    n_assert++; if (n != 400) begin n_fail++; $display("FAIL mixed_period got %0d want 400", n); end
    n_assert++; if (hi != 192) begin n_fail++; $display("FAIL jclk_high_cycles got %0d want 192", hi); end
    n_assert++; if (lo != 8) begin n_fail++; $display("FAIL load_low_cycles got %0d want 8", lo); end
    n_assert++; if (chg != 0) begin n_fail++; $display("FAIL partial_frame_changes got %0d want 0", chg); end
    n_assert++; if (joy1 !== 12'hA5C) begin n_fail++; $display("FAIL mixed_joy1 got %h want A5C", joy1); end
    n_assert++; if (joy2 !== 12'h369) begin n_fail++; $display("FAIL mixed_joy2 got %h want 369", joy2); end
  endtask

  task automatic test_reset_mid;
    int n;
    repeat (149) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_assert++; if (jclk !== 1'b0) begin n_fail++; $display("FAIL mid_reset_jclk got %b want 0", jclk); end
    n_assert++; if (jload_n !== 1'b1) begin n_fail++; $display("FAIL mid_reset_load_n got %b want 1", jload_n); end
    n_assert++; if (joy1 !== 12'h000) begin n_fail++; $display("FAIL mid_reset_joy1 got %h want 000", joy1); end
    n_assert++; if (joy2 !== 12'h000) begin n_fail++; $display("FAIL mid_reset_joy2 got %h want 000", joy2); end
    n_assert++; if (fv !== 1'b0) begin n_fail++; $display("FAIL mid_reset_fv got %b want 0", fv); end
    rst = 1'b0;
    n = 0;
    while (n < 1000) begin
      @(negedge clk); n++;
      if (fv === 1'b1) break;
    end
    n_assert++; if (n != 401) begin n_fail++; $display("FAIL post_reset_latency got %0d want 401", n); end
    n_assert++; if (joy1 !== 12'hA5C) begin n_fail++; $display("FAIL post_reset_joy1 got %h want A5C", joy1); end
    n_assert++; if (joy2 !== 12'h369) begin n_fail++; $display("FAIL post_reset_joy2 got %h want 369", joy2); end
  endtask

  task automatic test_enable_drop;
    int n, lo;
    logic seen;
    pat = 24'hFFF000;
    repeat (100) @(negedge clk);
    en = 1'b0;
    n = 0; seen = 1'b0;
    while (n < 1000) begin
      @(negedge clk); n++;
      if (fv === 1'b1) begin seen = 1'b1; break; end
    end
    n_assert++; if (seen !== 1'b1) begin n_fail++; $display("FAIL drop_frame_done got %b want 1", seen); end
    n_assert++; if (joy1 !== 12'h000 || joy2 !== 12'hFFF) begin
      n_fail++; $display("FAIL drop_frame_data got %h/%h want 000/FFF", joy1, joy2);
    end
    lo = 0;
    repeat (1000) begin
      @(negedge clk);
      if (jload_n === 1'b0) lo++;
    end
    n_assert++; if (lo != 0) begin n_fail++; $display("FAIL disabled_load_cycles got %0d want 0", lo); end
    en = 1'b1;
    n = 0; seen = 1'b0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (jload_n === 1'b0) begin seen = 1'b1; break; end
    end
    n_assert++; if (seen !== 1'b1) begin n_fail++; $display("FAIL reenable_load got %b want 1", seen); end
  endtask

  task automatic test_small;
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk); n++;
      if (fv2 === 1'b1) break;
    end
    n_assert++; if (joy1s !== 2'b10) begin n_fail++; $display("FAIL small_joy1 got %b want 10", joy1s); end
    n_assert++; if (joy2s !== 2'b01) begin n_fail++; $display("FAIL small_joy2 got %b want 01", joy2s); end
    n = 0;
    while (n < 100) begin
      @(negedge clk); n++;
      if (fv2 === 1'b1) break;
    end
    n_assert++; if (n != 20) begin n_fail++; $display("FAIL small_period got %0d want 20", n); end
  endtask

  task automatic test_no_overlap;
    n_assert++; if (viol != 0) begin n_fail++; $display("FAIL load_clk_overlap got %0d want 0", viol); end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    test_reset();
    test_no_press();
    test_edge_bits();
    test_mixed();
    test_reset_mid();
    test_enable_drop();
    test_small();
    test_no_overlap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/joy_serial_scanner.md
JOY_SERIAL_SCANNER -- requirements
Module: joy_serial_scanner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8, clk cycles per scan tick (min 2).
REQ-002 SHALL have parameter NBITS, default 24, total shift-register bits per frame (even, 2..32).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  permits a new frame to start.
REQ-006 SHALL have port JOY_DATA  input  1  serial data from the '165 chain, active-low buttons.
REQ-007 SHALL have port JOY_CLK  output  1  shift clock to the chain.
REQ-008 SHALL have port JOY_LOAD_N  output  1  parallel-load strobe, active-low.
REQ-009 SHALL have port joy1  output  NBITS/2  joystick 1, active-high pressed.
REQ-010 SHALL have port joy2  output  NBITS/2  joystick 2, active-high pressed.
REQ-011 SHALL have port frame_valid  output  1  one-cycle pulse when joy1/joy2 update.

Function
REQ-012 SHALL use a free-running divider that asserts tick on the cycle it equals CLK_DIV-1, then wraps to 0; first tick is CLK_DIV cycles after reset release.
REQ-013 SHALL implement states IDLE, LOAD, SHIFT0, SHIFT1, DONE; all transitions except DONE->IDLE occur only on tick.
REQ-014 IDLE: JOY_LOAD_N=1, JOY_CLK=0; on tick with enable=1 -> LOAD and drive JOY_LOAD_N=0 (registered).
REQ-015 LOAD: on tick -> SHIFT0, JOY_LOAD_N=1, bit counter=0.
REQ-016 SHIFT0: on tick, shift JOY_DATA into shift register LSB (register shifts left), drive JOY_CLK=1, -> SHIFT1.
REQ-017 SHIFT1: on tick, drive JOY_CLK=0; if bit counter=NBITS-1 -> DONE, else increment counter, -> SHIFT0.
REQ-018 DONE (one cycle, not tick-gated): joy1 <= ~sreg[NBITS-1:NBITS/2], joy2 <= ~sreg[NBITS/2-1:0], frame_valid=1, -> IDLE.
REQ-019 First sampled bit SHALL land in joy1 MSB; last sampled bit in joy2 LSB.
REQ-020 JOY_DATA SHALL be sampled with the pre-edge value on the same cycle JOY_CLK is driven high.
REQ-021 joy1/joy2 SHALL change only in DONE; partial frames never visible.
REQ-022 With enable held high, frame period SHALL be (2*NBITS+2)*CLK_DIV cycles (400 at defaults); frame_valid pulses exactly once per period.
REQ-023 enable deasserted mid-frame SHALL NOT abort the frame; it only blocks the next IDLE->LOAD.
REQ-024 JOY_LOAD_N=0 and JOY_CLK=1 SHALL never be asserted simultaneously.
REQ-025 All outputs SHALL be registered; no combinational path from JOY_DATA or enable to outputs.

Reset
REQ-026 reset=1 SHALL, on the next edge, force state IDLE, divider=0, counter=0, sreg=0, JOY_CLK=0, JOY_LOAD_N=1, joy1=0, joy2=0, frame_valid=0.
REQ-027 reset asserted mid-frame (any state) SHALL abort the frame with no frame_valid pulse and no output update.
REQ-028 reset SHALL take precedence over tick and enable in the same cycle.

Verification
REQ-029 Defaults, chain model returning 24'hFFFFFF (nothing pressed), enable=1 -> frame_valid every 400 cycles, joy1=12'h000, joy2=12'h000.
REQ-030 Chain model loaded with 24'h7FF_FFE (bit stream 0 first, 0 last) -> joy1=12'h800, joy2=12'h001 after first frame_valid.
REQ-031 Chain pattern 24'h5A3_C96 -> joy1=12'hA5C, joy2=12'h369; JOY_CLK high exactly 24 ticks per frame, JOY_LOAD_N low exactly 1 tick.
REQ-032 reset pulsed at cycle 150 of a frame -> JOY_CLK=0, JOY_LOAD_N=1, joy1/joy2=0 next cycle, no frame_valid until a full new frame completes.
REQ-033 enable dropped at cycle 100 of a frame -> that frame completes with frame_valid; no further JOY_LOAD_N pulse until enable returns.
REQ-034 CLK_DIV=2, NBITS=4, chain 4'b0110 -> period 20 cycles, joy1=2'b10, joy2=2'b01; assertion checks REQ-024 throughout.
